package_encoder: RTL

//  Transmit-side framer for the OFC package stream: serialises one package per accepted request as

---
 rtl/package_encoder_pkg.sv | 34 +++
 rtl/package_encoder_if.sv | 33 +++
 rtl/package_encoder_header_packer.sv | 35 +++
 rtl/package_encoder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/package_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ofc_pkg_defs (package)
//  Description : Shared constants, FSM encoding and header field bundle for
//                the OFC package stream transmit framer.
//  Revision    : 1.0 - initial release
// ============================================================================
package ofc_pkg_defs;

    localparam logic [15:0] COMMA_WORD = 16'h50BC;
    localparam logic [1:0]  TAG_HDR    = 2'b11;
    localparam logic [1:0]  TAG_ENE    = 2'b10;
    localparam logic [1:0]  TAG_TRL    = 2'b01;
    localparam int          N_HEADER   = 6;
    localparam logic [13:0] ENE_FILL   = 14'h3FFF;

    // Each state names the kind of word currently held on tx_data.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_ENE  = 2'd2,
        ST_TRL  = 2'd3
    } state_t;

    // Header fields captured when a package request is accepted.
    typedef struct packed {
        logic [28:0] ts;
        logic [8:0]  spill;
        logic [4:0]  slot;
        logic [13:0] evt;
    } hdr_fields_t;

endpackage
`default_nettype wire

// File: rtl/package_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : package_encoder_if
//  Description : Request, energy-sample and transmit-word bundle of the OFC
//                package framer. master = request/sample source, slave = framer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface package_encoder_if;
    logic        pkg_valid;
    logic        pkg_ready;
    logic [28:0] timestamp;
    logic [8:0]  spillno;
    logic [4:0]  slotno;
    logic [13:0] evtno;
    logic [13:0] ene_data;
    logic        ene_valid;
    logic        ene_ready;
    logic [15:0] tx_data;
    logic        tx_frame;
    logic        tx_done;
    logic        ene_underflow;

    modport master (
        output pkg_valid, timestamp, spillno, slotno, evtno, ene_data, ene_valid,
        input  pkg_ready, ene_ready, tx_data, tx_frame, tx_done, ene_underflow
    );

    modport slave (
        input  pkg_valid, timestamp, spillno, slotno, evtno, ene_data, ene_valid,
        output pkg_ready, ene_ready, tx_data, tx_frame, tx_done, ene_underflow
    );
endinterface
`default_nettype wire

// File: rtl/package_encoder_header_packer.sv
`default_nettype none
// ============================================================================
//  Module      : header_packer
//  Description : Combinational header word formatter: captured header fields
//                plus word index (0..5) -> 16-bit tagged header word.
//  Revision    : 1.0 - initial release
// ============================================================================
module header_packer
    import ofc_pkg_defs::*;
#(
    parameter int PACKAGE_LENGTH = 1036
) (
    input  hdr_fields_t fields_i,
    input  logic [2:0]  idx_i,
    output logic [15:0] word_o
);

    localparam logic [15:0] PKG_LEN = 16'(PACKAGE_LENGTH);

    // Select the header word layout for the requested index.
    always_comb begin
        word_o = {TAG_HDR, 14'h0};
        case (idx_i)
            3'd0:    word_o = {TAG_HDR, 6'b0, PKG_LEN[15:8]};
            3'd1:    word_o = {TAG_HDR, 1'b0, fields_i.ts[28], 4'b0, PKG_LEN[7:0]};
            3'd2:    word_o = {TAG_HDR, fields_i.ts[27:14]};
            3'd3:    word_o = {TAG_HDR, fields_i.ts[13:0]};
            3'd4:    word_o = {TAG_HDR, fields_i.spill[7:0], fields_i.spill[8], fields_i.slot};
            3'd5:    word_o = {TAG_HDR, fields_i.evt};
            default: word_o = {TAG_HDR, 14'h0};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/package_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : package_encoder
//  Description : OFC transmit framer. Emits one 16-bit word per clock: comma
//                idle words (50BC) between packages, and per accepted request
//                6 header words, N_ENERGY energy words and N_TRAILER trailer
//                words. Packages never stall; missing samples become fill.
//                Optional feature macro: OFC_TX_CHECKSUM_EN (XOR of energy
//                fields placed in trailer word 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module package_encoder
    import ofc_pkg_defs::*;
#(
    parameter int PACKAGE_LENGTH = 1036,
    parameter int N_ENERGY       = 1024,
    parameter int MIN_GAP        = 1
) (
    input  logic             clk,
    input  logic             live_rising,
    package_encoder_if.slave bus
);

    localparam int N_TRAILER = PACKAGE_LENGTH - N_HEADER - N_ENERGY;
    localparam int CNT_W     = $clog2(PACKAGE_LENGTH + 1);
    localparam int GAP_W     = $clog2(MIN_GAP + 1);

    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(N_HEADER - 1);
    localparam logic [CNT_W-1:0] ENE_LAST = CNT_W'(N_ENERGY - 1);
    localparam logic [CNT_W-1:0] TRL_LAST = CNT_W'(N_TRAILER - 1);
    localparam logic [GAP_W-1:0] GAP_SAT  = GAP_W'(MIN_GAP);

    generate
        if (N_TRAILER < 1) begin : g_bad_trailer
            $error("package_encoder: PACKAGE_LENGTH leaves no room for a trailer word");
        end
        if (MIN_GAP < 1) begin : g_bad_gap
            $error("package_encoder: MIN_GAP must be at least 1");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    hdr_fields_t      fields_q, fields_d;
    logic [15:0]      tx_data_q, tx_data_d;
    logic             tx_frame_q, tx_frame_d;
    logic             tx_done_q, tx_done_d;
    logic             und_q, und_d;
    logic             pkg_ready_q, pkg_ready_d;
    logic             ene_ready_q, ene_ready_d;

    logic             w_accept;
    logic             w_ene_emit;
    logic [13:0]      w_ene_field;
    logic [15:0]      w_ene_word;
    logic [15:0]      w_trl0_word;
    hdr_fields_t      w_hdr_fields;
    logic [2:0]       w_hdr_idx;
    logic [15:0]      w_hdr_word;

    assign w_accept    = bus.pkg_valid && pkg_ready_q;
    assign w_ene_field = bus.ene_valid ? bus.ene_data : ENE_FILL;
    assign w_ene_word  = {TAG_ENE, w_ene_field};

    // Header word source: live inputs for word 0 at accept, captured fields after.
    always_comb begin
        w_hdr_fields = fields_q;
        w_hdr_idx    = cnt_q[2:0] + 3'd1;
        if (state_q == ST_IDLE) begin
            w_hdr_fields = '{ts: bus.timestamp, spill: bus.spillno,
                             slot: bus.slotno, evt: bus.evtno};
            w_hdr_idx    = 3'd0;
        end
    end

    header_packer #(
        .PACKAGE_LENGTH (PACKAGE_LENGTH)
    ) u_header_packer (
        .fields_i (w_hdr_fields),
        .idx_i    (w_hdr_idx),
        .word_o   (w_hdr_word)
    );

`ifdef OFC_TX_CHECKSUM_EN
    logic [13:0] xor_q, xor_d;

    // Running XOR over every energy field sent, restarted at each accept.
    always_comb begin
        xor_d = xor_q;
        if (w_accept) begin
            xor_d = '0;
        end else if (w_ene_emit) begin
            xor_d = xor_q ^ w_ene_field;
        end
    end

    // Checksum accumulator register.
    always_ff @(posedge clk) begin
        if (live_rising) begin
            xor_q <= '0;
        end else begin
            xor_q <= xor_d;
        end
    end

    assign w_trl0_word = {TAG_TRL, xor_q};
`else
    assign w_trl0_word = {TAG_TRL, 14'h0};
`endif

    // Next word selection, FSM transitions and registered output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        fields_d   = fields_q;
        und_d      = und_q;
        tx_data_d  = COMMA_WORD;
        w_ene_emit = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    state_d   = ST_HDR;
                    cnt_d     = '0;
                    gap_d     = '0;
                    fields_d  = w_hdr_fields;
                    und_d     = 1'b0;
                    tx_data_d = w_hdr_word;
                end else if (gap_q < GAP_SAT) begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_HDR: begin
                if (cnt_q == HDR_LAST) begin
                    state_d    = ST_ENE;
                    cnt_d      = '0;
                    tx_data_d  = w_ene_word;
                    w_ene_emit = 1'b1;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    tx_data_d = w_hdr_word;
                end
            end
            ST_ENE: begin
                if (cnt_q == ENE_LAST) begin
                    state_d   = ST_TRL;
                    cnt_d     = '0;
                    tx_data_d = w_trl0_word;
                end else begin
                    cnt_d      = cnt_q + 1'b1;
                    tx_data_d  = w_ene_word;
                    w_ene_emit = 1'b1;
                end
            end
            ST_TRL: begin
                if (cnt_q == TRL_LAST) begin
                    // The comma emitted here is the first gap word.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    gap_d   = GAP_W'(1);
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    tx_data_d = {TAG_TRL, 14'h0};
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (w_ene_emit && !bus.ene_valid) begin
            und_d = 1'b1;
        end

        tx_frame_d  = (state_d != ST_IDLE);
        tx_done_d   = (state_d == ST_TRL) && (cnt_d == TRL_LAST);
        ene_ready_d = ((state_d == ST_HDR) && (cnt_d == HDR_LAST)) ||
                      ((state_d == ST_ENE) && (cnt_d != ENE_LAST));
        pkg_ready_d = (state_d == ST_IDLE) && (gap_d >= GAP_SAT);
    end

    // State and output registers; reset abandons any package in flight.
    always_ff @(posedge clk) begin
        if (live_rising) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            gap_q       <= GAP_SAT;
            fields_q    <= '0;
            tx_data_q   <= COMMA_WORD;
            tx_frame_q  <= 1'b0;
            tx_done_q   <= 1'b0;
            und_q       <= 1'b0;
            pkg_ready_q <= 1'b0;
            ene_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            fields_q    <= fields_d;
            tx_data_q   <= tx_data_d;
            tx_frame_q  <= tx_frame_d;
            tx_done_q   <= tx_done_d;
            und_q       <= und_d;
            pkg_ready_q <= pkg_ready_d;
            ene_ready_q <= ene_ready_d;
        end
    end

    assign bus.tx_data       = tx_data_q;
    assign bus.tx_frame      = tx_frame_q;
    assign bus.tx_done       = tx_done_q;
    assign bus.ene_underflow = und_q;
    assign bus.pkg_ready     = pkg_ready_q;
    assign bus.ene_ready     = ene_ready_q;

endmodule
`default_nettype wire
